// File: rtl/phys_free_list.sv
// Free list for the physical register file: a circular FIFO of free register
// indices with up to two grants and two releases per cycle, plus a free bitmap.
module phys_free_list #(
    parameter int unsigned NUM_PHYS = 64,
    parameter int unsigned NUM_ARCH = 32,
    parameter int unsigned PW       = 6,
    parameter int unsigned DEPTH    = NUM_PHYS - NUM_ARCH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alloc_req_1,
    input  logic                         alloc_req_2,
    output logic                         alloc_gnt,
    output logic [PW-1:0]                alloc_p_1,
    output logic [PW-1:0]                alloc_p_2,
    output logic                         alloc_stall,
    input  logic                         rt_flag_1,
    input  logic [PW-1:0]                fp_i_1,
    input  logic                         rt_flag_2,
    input  logic [PW-1:0]                fp_i_2,
    output logic [$clog2(DEPTH+1)-1:0]   free_count,
    output logic                         err
);

    // Pointers wrap naturally because DEPTH is a power of two.
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [PW-1:0]       r_fifo [DEPTH];
    logic [AW-1:0]       r_head;
    logic [AW-1:0]       r_tail;
    logic [CW-1:0]       r_count;
    logic [NUM_PHYS-1:0] r_free_bm;
    logic                r_err;

    logic [1:0]          w_n_req;
    logic [1:0]          w_n_gnt;
    logic [1:0]          w_n_rel;
    logic [AW-1:0]       w_head_p1;
    logic [AW-1:0]       w_tail_p1;
    logic [AW-1:0]       w_wr_idx_2;
    logic                w_gnt;
    logic                w_rel_ok_1;
    logic                w_rel_ok_2;
    logic                w_dup_2;
    logic                w_room_1;
    logic                w_room_2;
    logic                w_rel_err;
    logic [NUM_PHYS-1:0] w_free_bm_nxt;

    // Allocation side: purely from registered state and this cycle's requests.
    always_comb begin
        w_n_req   = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        w_head_p1 = AW'(r_head + AW'(1));
        w_gnt     = (w_n_req != 2'd0) && (r_count >= CW'(w_n_req));
        w_n_gnt   = w_gnt ? w_n_req : 2'd0;
    end

    assign alloc_gnt   = w_gnt;
    assign alloc_stall = (w_n_req != 2'd0) && !w_gnt;
    assign alloc_p_1   = r_fifo[r_head];
    assign alloc_p_2   = alloc_req_1 ? r_fifo[w_head_p1] : r_fifo[r_head];

    // Release side: checks use pre-allocation count and bitmap, slot 1 first.
    always_comb begin
        w_room_1   = r_count < CW'(DEPTH);
        w_rel_ok_1 = rt_flag_1 && !r_free_bm[fp_i_1] && w_room_1;
        w_dup_2    = w_rel_ok_1 && (fp_i_1 == fp_i_2);
        w_room_2   = (r_count + CW'(w_rel_ok_1)) < CW'(DEPTH);
        w_rel_ok_2 = rt_flag_2 && !r_free_bm[fp_i_2] && !w_dup_2 && w_room_2;
        w_rel_err  = (rt_flag_1 && !w_rel_ok_1) || (rt_flag_2 && !w_rel_ok_2);
        w_n_rel    = {1'b0, w_rel_ok_1} + {1'b0, w_rel_ok_2};
        w_tail_p1  = AW'(r_tail + AW'(1));
        w_wr_idx_2 = w_rel_ok_1 ? w_tail_p1 : r_tail;
    end

    // Granted and released sets are disjoint: a granted register still reads free.
    always_comb begin
        w_free_bm_nxt = r_free_bm;
        if (w_gnt && alloc_req_1) begin
            w_free_bm_nxt[alloc_p_1] = 1'b0;
        end
        if (w_gnt && alloc_req_2) begin
            w_free_bm_nxt[alloc_p_2] = 1'b0;
        end
        if (w_rel_ok_1) begin
            w_free_bm_nxt[fp_i_1] = 1'b1;
        end
        if (w_rel_ok_2) begin
            w_free_bm_nxt[fp_i_2] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_fifo[i] <= PW'(NUM_ARCH + i);
            end
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= CW'(DEPTH);
            r_free_bm <= {{DEPTH{1'b1}}, {NUM_ARCH{1'b0}}};
            r_err     <= 1'b0;
        end else begin
            if (w_rel_ok_1) begin
                r_fifo[r_tail] <= fp_i_1;
            end
            if (w_rel_ok_2) begin
                r_fifo[w_wr_idx_2] <= fp_i_2;
            end
            r_head    <= AW'(r_head + AW'(w_n_gnt));
            r_tail    <= AW'(r_tail + AW'(w_n_rel));
            r_count   <= CW'(r_count - CW'(w_n_gnt) + CW'(w_n_rel));
            r_free_bm <= w_free_bm_nxt;
            if (w_rel_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign free_count = r_count;
    assign err        = r_err;

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: a directed vector table, corner-case sequences and
// random traffic, all checked against a queue-based reference model.
module tb_phys_free_list;

    logic       clk;
    logic       rst;
    logic       alloc_req_1;
    logic       alloc_req_2;
    logic       alloc_gnt;
    logic [5:0] alloc_p_1;
    logic [5:0] alloc_p_2;
    logic       alloc_stall;
    logic       rt_flag_1;
    logic [5:0] fp_i_1;
    logic       rt_flag_2;
    logic [5:0] fp_i_2;
    logic [5:0] free_count;
    logic       err;

    phys_free_list dut (
        .clk         (clk),
        .rst         (rst),
        .alloc_req_1 (alloc_req_1),
        .alloc_req_2 (alloc_req_2),
        .alloc_gnt   (alloc_gnt),
        .alloc_p_1   (alloc_p_1),
        .alloc_p_2   (alloc_p_2),
        .alloc_stall (alloc_stall),
        .rt_flag_1   (rt_flag_1),
        .fp_i_1      (fp_i_1),
        .rt_flag_2   (rt_flag_2),
        .fp_i_2      (fp_i_2),
        .free_count  (free_count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit gnt;
        bit stall;
        int a1;
        bit a1_v;
        int a2;
        bit a2_v;
        int cnt;
        bit er;
    } exp_t;

    typedef struct {
        bit r1;
        bit r2;
        bit f1;
        int p1;
        bit f2;
        int p2;
        bit gnt;
        int a1;
        int a2;
        bit stall;
        int cnt;
        bit er;
    } vec_t;

    int        mq[$];
    bit [63:0] mbm;
    bit        merr;
    exp_t      exp_q[$];
    int        n_checks = 0;
    int        n_pass   = 0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endtask

    function automatic void model_reset();
        mq.delete();
        for (int i = 32; i < 64; i++) mq.push_back(i);
        mbm  = '0;
        for (int i = 32; i < 64; i++) mbm[i] = 1'b1;
        merr = 1'b0;
    endfunction

    // Releases are judged one slot at a time against a running copy of the
    // pre-grant bitmap and occupancy; grants pop from the front of the queue.
    function automatic void model_step();
        int        n;
        int        sz;
        int        tsz;
        int        p;
        bit        g;
        bit [63:0] tbm;
        int        rel[$];
        if (rst) begin
            model_reset();
            return;
        end
        sz  = mq.size();
        n   = int'(alloc_req_1) + int'(alloc_req_2);
        g   = (n > 0) && (sz >= n);
        tbm = mbm;
        tsz = sz;
        if (rt_flag_1) begin
            if (!tbm[fp_i_1] && tsz < 32) begin
                rel.push_back(int'(fp_i_1)); tbm[fp_i_1] = 1'b1; tsz++;
            end else merr = 1'b1;
        end
        if (rt_flag_2) begin
            if (!tbm[fp_i_2] && tsz < 32) begin
                rel.push_back(int'(fp_i_2)); tbm[fp_i_2] = 1'b1; tsz++;
            end else merr = 1'b1;
        end
        if (g) begin
            for (int k = 0; k < n; k++) begin
                p = mq.pop_front();
                mbm[p] = 1'b0;
            end
        end
        foreach (rel[k]) begin
            mq.push_back(rel[k]);
            mbm[rel[k]] = 1'b1;
        end
    endfunction

    // Drive inputs, queue the model's expectation, compare at the falling edge.
    task automatic drive(input bit r1, input bit r2, input bit f1, input int p1,
                         input bit f2, input int p2);
        exp_t e;
        int   n;
        int   sz;
        alloc_req_1 = r1;
        alloc_req_2 = r2;
        rt_flag_1   = f1;
        fp_i_1      = 6'(p1);
        rt_flag_2   = f2;
        fp_i_2      = 6'(p2);
        n  = int'(r1) + int'(r2);
        sz = mq.size();
        e.gnt   = (n > 0) && (sz >= n);
        e.stall = (n > 0) && !e.gnt;
        e.a1_v  = sz >= 1;
        e.a1    = (sz >= 1) ? mq[0] : 0;
        if (r1) begin
            e.a2_v = sz >= 2;
            e.a2   = (sz >= 2) ? mq[1] : 0;
        end else begin
            e.a2_v = sz >= 1;
            e.a2   = (sz >= 1) ? mq[0] : 0;
        end
        e.cnt = sz;
        e.er  = merr;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        chk("sb_gnt", int'(alloc_gnt), int'(e.gnt));
        chk("sb_stall", int'(alloc_stall), int'(e.stall));
        if (e.a1_v) chk("sb_p1", int'(alloc_p_1), e.a1);
        if (e.a2_v) chk("sb_p2", int'(alloc_p_2), e.a2);
        chk("sb_count", int'(free_count), e.cnt);
        chk("sb_err", int'(err), int'(e.er));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset(input bit r1, input bit r2);
        rst         = 1'b1;
        alloc_req_1 = r1;
        alloc_req_2 = r2;
        rt_flag_1   = 1'b0;
        rt_flag_2   = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    vec_t vt[8];

    initial begin
        vt[0] = '{1, 1, 0,  0, 0,  0, 1, 32, 33, 0, 32, 0};
        vt[1] = '{0, 0, 0,  0, 0,  0, 0, 34, 34, 0, 30, 0};
        vt[2] = '{1, 0, 0,  0, 0,  0, 1, 34, 35, 0, 30, 0};
        vt[3] = '{0, 1, 0,  0, 0,  0, 1, 35, 35, 0, 29, 0};
        vt[4] = '{0, 0, 1, 32, 0,  0, 0, 36, 36, 0, 28, 0};
        vt[5] = '{1, 1, 1, 32, 0,  0, 1, 36, 37, 0, 29, 0};
        vt[6] = '{0, 0, 0,  0, 0,  0, 0, 38, 38, 0, 27, 1};
        vt[7] = '{0, 1, 0,  0, 1, 36, 1, 38, 38, 0, 27, 1};

        rst = 1'b0; alloc_req_1 = 1'b0; alloc_req_2 = 1'b0;
        rt_flag_1 = 1'b0; rt_flag_2 = 1'b0; fp_i_1 = '0; fp_i_2 = '0;
        model_reset();

        // Reset state, paired/single grants and a duplicate release.
        do_reset(0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("rst_count", int'(free_count), 32);
        chk("rst_err", int'(err), 0);
        chk("rst_p1", int'(alloc_p_1), 32);
        chk("rst_p2", int'(alloc_p_2), 32);
        tick();
        foreach (vt[i]) begin
            drive(vt[i].r1, vt[i].r2, vt[i].f1, vt[i].p1, vt[i].f2, vt[i].p2);
            chk("vec_gnt", int'(alloc_gnt), int'(vt[i].gnt));
            chk("vec_p1", int'(alloc_p_1), vt[i].a1);
            chk("vec_p2", int'(alloc_p_2), vt[i].a2);
            chk("vec_stall", int'(alloc_stall), int'(vt[i].stall));
            chk("vec_count", int'(free_count), vt[i].cnt);
            chk("vec_err", int'(err), int'(vt[i].er));
            tick();
        end

        // Drain to empty, then a release in the stalled cycle.
        do_reset(0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 1, 5, 0, 0);
        chk("empty_stall", int'(alloc_stall), 1);
        chk("empty_gnt", int'(alloc_gnt), 0);
        chk("empty_count", int'(free_count), 0);
        tick();
        drive(1, 0, 0, 0, 0, 0);
        chk("rel_gnt", int'(alloc_gnt), 1);
        chk("rel_p1", int'(alloc_p_1), 5);
        tick();

        // One entry left.
        drive(0, 0, 1, 40, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        chk("one_pair_gnt", int'(alloc_gnt), 0);
        chk("one_pair_stall", int'(alloc_stall), 1);
        tick();
        drive(0, 1, 0, 0, 0, 0);
        chk("one_count", int'(free_count), 1);
        chk("one_gnt", int'(alloc_gnt), 1);
        chk("one_p2", int'(alloc_p_2), 40);
        tick();

        // Same register on both release slots, then a repeat release.
        drive(0, 0, 1, 40, 1, 40);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("dup_count", int'(free_count), 1);
        chk("dup_err", int'(err), 1);
        tick();
        drive(0, 0, 1, 40, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("dup2_count", int'(free_count), 1);
        chk("dup2_err", int'(err), 1);
        tick();

        // Dual release straddling positions 31 and 0, then a straddling grant.
        do_reset(0, 0);
        for (int i = 0; i < 16; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        for (int k = 10; k <= 40; k++) begin
            drive(0, 0, 1, k, 0, 0);
            tick();
        end
        drive(1, 1, 0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 7, 1, 9);
        chk("wrap_pre_count", int'(free_count), 29);
        tick();
        for (int i = 0; i < 14; i++) begin
            drive(1, 1, 0, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        chk("wrap_gnt", int'(alloc_gnt), 1);
        chk("wrap_p1", int'(alloc_p_1), 7);
        chk("wrap_p2", int'(alloc_p_2), 9);
        tick();

        // Reset with requests after an error.
        drive(0, 0, 1, 50, 1, 50);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_err", int'(err), 1);
        tick();
        do_reset(1, 1);
        drive(0, 0, 0, 0, 0, 0);
        chk("mid_rst_count", int'(free_count), 32);
        chk("mid_rst_err", int'(err), 0);
        tick();
        drive(1, 1, 0, 0, 0, 0);
        chk("mid_rst_gnt", int'(alloc_gnt), 1);
        chk("mid_rst_p1", int'(alloc_p_1), 32);
        chk("mid_rst_p2", int'(alloc_p_2), 33);
        tick();

        // Release while full, alongside a grant: still dropped.
        do_reset(0, 0);
        drive(1, 0, 1, 0, 0, 0);
        chk("full_gnt", int'(alloc_gnt), 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        chk("full_count", int'(free_count), 31);
        chk("full_err", int'(err), 1);
        tick();

        // Random mixed traffic.
        do_reset(0, 0);
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 63)),
                  1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 63)));
            tick();
            if (i == 300) do_reset(0, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
